// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between truth_table_sweeper and its circuit under test.
// The pass/mismatch_idx signals exist only when TTS_COMPARE_EN is defined.
interface truth_table_sweeper_if #(
    parameter int unsigned WIDTH = 3
);
    logic                    start;
    logic                    abort;
    logic                    z;
    logic [WIDTH-1:0]        abc;
    logic                    busy;
    logic                    done;
    logic [(2**WIDTH)-1:0]   table_out;
`ifdef TTS_COMPARE_EN
    logic                    pass;
    logic [WIDTH-1:0]        mismatch_idx;

    modport master (
        output start, abort, z,
        input  abc, busy, done, table_out, pass, mismatch_idx
    );

    modport slave (
        input  start, abort, z,
        output abc, busy, done, table_out, pass, mismatch_idx
    );
`else
    modport master (
        output start, abort, z,
        input  abc, busy, done, table_out
    );

    modport slave (
        input  start, abort, z,
        output abc, busy, done, table_out
    );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: walks every WIDTH-bit vector, holds each DWELL cycles, captures z.
// Optional TTS_COMPARE_EN adds a registered comparison of the captured table against EXPECTED.
module truth_table_sweeper #(
    parameter int unsigned           WIDTH    = 3,
    parameter int unsigned           DWELL    = 20,
    parameter logic [(2**WIDTH)-1:0] EXPECTED = 8'hEA
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_sweeper_if.slave bus
);
    localparam int unsigned      Entries   = 2 ** WIDTH;
    // A dwell of 0 behaves as 1; the counter is 16 bits wide.
    localparam int unsigned      DwellEff  = (DWELL == 0) ? 1 : ((DWELL > 65535) ? 65535 : DWELL);
    localparam logic [15:0]      DwellLast = 16'(DwellEff - 1);
    localparam logic [WIDTH-1:0] VecLast   = WIDTH'(Entries - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic [15:0]        dwell_q, dwell_d;
    logic [Entries-1:0] table_q, table_d;
    logic               accept;
    logic               sweep_end;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        dwell_d   = dwell_q;
        table_d   = table_q;
        accept    = 1'b0;
        sweep_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    accept  = 1'b1;
                    table_d = '0;
                    vec_d   = '0;
                    dwell_d = '0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                // abort wins even over the final sample, which is then dropped
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (dwell_q == DwellLast) begin
                    table_d[vec_q] = bus.z;
                    dwell_d        = '0;
                    if (vec_q == VecLast) begin
                        sweep_end = 1'b1;
                        state_d   = StDone;
                    end else begin
                        vec_d = vec_q + WIDTH'(1);
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            dwell_q <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            table_q <= table_d;
        end
    end

    // vec_q keeps the final vector through DONE, so abc holds it there.
    assign bus.abc       = (state_q == StIdle) ? '0 : vec_q;
    assign bus.busy      = (state_q == StDrive);
    assign bus.done      = (state_q == StDone);
    assign bus.table_out = table_q;

`ifdef TTS_COMPARE_EN
    logic               pass_q, pass_d;
    logic [WIDTH-1:0]   midx_q, midx_d;
    logic [Entries-1:0] diff;

    always_comb begin
        pass_d = pass_q;
        midx_d = midx_q;
        diff   = table_d ^ EXPECTED;
        if (accept) begin
            pass_d = 1'b0;
            midx_d = '0;
        end else if (sweep_end) begin
            pass_d = (diff == '0);
            midx_d = '0;
            // Scan downwards so the lowest differing index is the one kept.
            for (int i = int'(Entries) - 1; i >= 0; i--) begin
                if (diff[i]) begin
                    midx_d = WIDTH'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
            midx_q <= '0;
        end else begin
            pass_q <= pass_d;
            midx_q <= midx_d;
        end
    end

    assign bus.pass         = pass_q;
    assign bus.mismatch_idx = midx_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{EXPECTED, accept, sweep_end};
`endif
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of a small combinational circuit under test and consumes its output. On a start request it drives every WIDTH-bit input combination in ascending order, holding each for a programmable number of clock cycles. It samples the circuit's single-bit output at the end of each hold interval and assembles a 2^WIDTH-bit truth table. The sweep is the synthesizable, clocked counterpart of an exhaustive input walk, so the same sweep can run in hardware and in simulation.

## Interface
- WIDTH, 3, number of circuit inputs; table has 2^WIDTH entries.
- DWELL, 20, clock cycles each vector is held (legal range 1..65535; 0 is treated as 1).
- EXPECTED, 8'hEA, reference truth table, 2^WIDTH bits (used only with TTS_COMPARE_EN).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- abort  input  1  synchronous sweep cancel.
- z  input  1  output of circuit under test (combinational function of abc).
- abc  output  WIDTH  current input vector; abc[WIDTH-1] is A, abc[0] is the last input.
- busy  output  1  high in DRIVE.
- done  output  1  one-cycle pulse when a full sweep completes.
- table_out  output  2^WIDTH  captured truth table; bit i is z for abc == i.
- pass  output  1  (TTS_COMPARE_EN only) table_out == EXPECTED, valid with done.
- mismatch_idx  output  WIDTH  (TTS_COMPARE_EN only) lowest index where table_out and EXPECTED differ; 0 if none.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: abc=0, busy=0. When start=1 and abort=0, clear table_out, vec=0, dwell_cnt=0, and go to DRIVE.
- DRIVE: abc=vec. dwell_cnt increments each cycle. On dwell_cnt==DWELL-1, set table_out[vec]<=z and dwell_cnt<=0.
  - If vec == 2^WIDTH-1, go to DONE.
  - Otherwise vec<=vec+1.
- DONE: done=1 for exactly one cycle; abc holds the final vector. Next state is IDLE.
- abort=1 in DRIVE: go to IDLE next cycle with no done pulse. table_out keeps the bits already captured; uncaptured bits stay 0.
- abort has priority over start and over a coinciding final sample (that final sample is not written).
- start while busy or in DONE is ignored; it is not queued.
- vec and dwell_cnt do not wrap mid-sweep. vec terminates at 2^WIDTH-1. dwell_cnt is 16 bits.
- table_out holds its value in IDLE until the next accepted start.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, abc=0, busy=0, done=0, table_out=0, pass=0, mismatch_idx=0. Applies mid-sweep identically.
- start accepted at edge k: abc=0 and busy=1 from cycle k+1.
- Vector i is driven during cycles k+1+i·DWELL through k+(i+1)·DWELL.
  - z is sampled at the last of those cycles, which gives DWELL-1 settling cycles.
- done is high during cycle k+1+2^WIDTH·DWELL. busy is low in that cycle. IDLE follows.
- Total sweep latency from start acceptance to done is 2^WIDTH·DWELL+1 cycles. For the defaults this is 161.
- A new start is accepted earliest in the cycle after done.
- z is assumed stable at the sampling edge; the block adds no synchronizer.

## Configuration
- TTS_COMPARE_EN defined:
  - pass and mismatch_idx are registered on the DONE transition and are valid while done=1.
  - Both hold their values until the next accepted start, which clears them to 0.
- TTS_COMPARE_EN undefined: the pass and mismatch_idx ports and the comparison logic are absent; EXPECTED is unused.

## Test plan
- Circuit z=(A&B)|C, defaults, start pulse after reset:
  - abc steps 0→7 every 20 cycles.
  - done at start+161.
  - table_out=8'hEA, pass=1, mismatch_idx=0.
- Same circuit, EXPECTED=8'hEB: pass=0, mismatch_idx=0 (TTS_COMPARE_EN).
- DWELL=1: abc changes every cycle, done at start+9, table_out correct.
- abort asserted at cycle start+50 (vector 2): no done pulse, IDLE next cycle, table_out=8'b0000_0010.
- rst_n=0 for one cycle during vector 5: all outputs zero next cycle; a following start performs a full clean sweep.
- start held high continuously: sweeps run back-to-back with one IDLE cycle between done and the next abc=0; start pulses during busy have no effect.
